jump_target_encoder: RTL and testbench

Inverse of the datapath's jump-address formation: takes a 32-bit byte target address, the current PC+4 and a J-format opcode, and packs them into a 32-bit J-type instruction word (opcode, target[27:2]). It flags targets that the fetch-side shift-left-2/upper-4-bit concatenation cannot reproduce. It sits between the assembler/loader path and instruction memory write port, with a valid/ready stream on each side and a one-entry skid buffer so backpressure never drops a word. Saturating statistics counters support loader self-check.

---
 rtl/jump_pkg.sv | 25 ++
 rtl/jenc_skid.sv | 35 +++
 rtl/jump_target_encoder.sv | 46 ++++
 tb/tb_jump_target_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// jump_pkg: shared J-format field widths, opcodes, error-bit layout and error rule
package jump_pkg;
  localparam int OPCODE_W = 6;
  localparam int JIDX_W = 26;
  localparam int REGION_W = 4;
  localparam int ERR_W = 3;
  localparam int ERR_MISALIGNED = 0;
  localparam int ERR_REGION = 1;
  localparam int ERR_OPCODE = 2;
  localparam int PAYLOAD_W = 32 + ERR_W;
  localparam logic [OPCODE_W-1:0] OP_J = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL = 6'h03;
  function automatic logic [ERR_W-1:0] jump_errs(
    input logic [OPCODE_W-1:0] op,
    input logic [31:0] target,
    input logic [31:0] pc4
  );
    logic [ERR_W-1:0] e;
    e = '0;
    e[ERR_MISALIGNED] = |target[1:0];
    e[ERR_REGION] = target[31 -: REGION_W] != pc4[31 -: REGION_W];
    e[ERR_OPCODE] = op != OP_J && op != OP_JAL;
    return e;
  endfunction
endpackage

// File: rtl/jenc_skid.sv
// jenc_skid: registered primary output stage plus one skid entry, strict FIFO
module jenc_skid #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] pri_q, skid_q;
  logic pri_v, skid_v, take, load;
  assign in_ready = !skid_v;
  assign out_valid = pri_v;
  assign out_data = pri_q;
  assign take = in_valid && !skid_v;
  assign load = !pri_v || out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pri_q <= '0;
      skid_q <= '0;
      pri_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (load) begin
      pri_v <= skid_v || take;
      if (skid_v || take) pri_q <= skid_v ? skid_q : in_data;
      skid_v <= 1'b0;
    end else if (take) begin
      skid_q <= in_data;
      skid_v <= 1'b1;
    end
endmodule

// File: rtl/jump_target_encoder.sv
// jump_target_encoder: packs byte jump targets into J-type words with error flags and stats
module jump_target_encoder
  import jump_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [31:0]         in_target,
  input  logic [31:0]         in_pc4,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ERR_W-1:0]    out_err,
  input  logic                clr_counts,
  output logic [15:0]         jump_count,
  output logic [15:0]         err_count
);
  logic [PAYLOAD_W-1:0] enc, payload;
  logic xfer;
  assign enc = {jump_errs(in_opcode, in_target, in_pc4), in_opcode, in_target[JIDX_W+1:2]};
  assign {out_err, out_instr} = payload;
  assign xfer = out_valid && out_ready;
  jenc_skid #(.W(PAYLOAD_W)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(enc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(payload)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      jump_count <= '0;
      err_count <= '0;
    end else if (clr_counts) begin
      jump_count <= '0;
      err_count <= '0;
    end else if (xfer) begin
      if (out_err == '0) jump_count <= jump_count + 16'(jump_count != 16'hFFFF);
      else err_count <= err_count + 16'(err_count != 16'hFFFF);
    end
endmodule

// File: tb/tb_jump_target_encoder.sv
// tb_jump_target_encoder: random + directed scoreboard bench for jump_target_encoder
module tb_jump_target_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [5:0] in_opcode = '0;
  logic [31:0] in_target = '0;
  logic [31:0] in_pc4 = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [2:0] out_err;
  logic clr_counts = 1'b0;
  logic [15:0] jump_count, err_count;
  int errors = 0;
  int checks = 0;
  int rdy_mode = 1;
  logic [34:0] sbq[$];
  logic [34:0] mon_e;
  int jc_total = 0;
  int ec_total = 0;
  logic [31:0] held;

  jump_target_encoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opcode(in_opcode),
    .in_target(in_target),
    .in_pc4(in_pc4),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_err(out_err),
    .clr_counts(clr_counts),
    .jump_count(jump_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
  end

  function automatic logic [34:0] model(input logic [5:0] op, input logic [31:0] t, input logic [31:0] p);
    logic [31:0] instr;
    logic mis, reg_bad, op_bad;
    instr = ({26'd0, op} << 26) | ((t >> 2) & 32'h03FF_FFFF);
    mis = (t % 4) != 0;
    reg_bad = (t >> 28) != (p >> 28);
    op_bad = !(op == 6'h02 || op == 6'h03);
    return {op_bad, reg_bad, mis, instr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int n);
    return n > 65535 ? 32'd65535 : 32'(n);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      jc_total = 0;
      ec_total = 0;
    end else begin
      check("jump_count", 32'(jump_count), sat(jc_total));
      check("err_count", 32'(err_count), sat(ec_total));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) check("unexpected_output", 32'(out_valid), 32'd0);
        else begin
          mon_e = sbq.pop_front();
          check("out_instr", out_instr, mon_e[31:0]);
          check("out_err", 32'(out_err), 32'(mon_e[34:32]));
          if (mon_e[34:32] == 3'b000) jc_total++;
          else ec_total++;
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(in_opcode, in_target, in_pc4));
      if (clr_counts) begin
        jc_total = 0;
        ec_total = 0;
      end
    end
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  // call right after a posedge; returns 1 ns after the posedge that took the word
  task automatic send(input logic [5:0] op, input logic [31:0] t, input logic [31:0] p);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_opcode = op;
    in_target = t;
    in_pc4 = p;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic direct(input string name, input logic [5:0] op, input logic [31:0] t,
                        input logic [31:0] p, input logic [31:0] ei, input logic [2:0] ee);
    send(op, t, p);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_instr"}, out_instr, ei);
    check({name, "_err"}, 32'(out_err), 32'(ee));
  endtask

  task automatic rand_word;
    logic [31:0] t, p;
    logic [5:0] op;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    p = $urandom;
    if ($urandom_range(0, 1) == 1) p[31:28] = t[31:28];
    op = $urandom_range(0, 3) != 0 ? 6'($urandom_range(2, 3)) : 6'($urandom);
    send(op, t, p);
  endtask

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_jump_count", 32'(jump_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    sync();
    direct("j", 6'h02, 32'h0040_0010, 32'h0040_0004, 32'h0810_0004, 3'b000);
    @(negedge clk);
    check("jc_after_j", 32'(jump_count), 32'd1);
    sync();
    direct("jal", 6'h03, 32'h0040_0010, 32'h0040_0004, 32'h0C10_0004, 3'b000);
    sync();
    direct("misalign", 6'h02, 32'h0040_0012, 32'h0040_0004, 32'h0810_0004, 3'b001);
    @(negedge clk);
    check("ec_after_mis", 32'(err_count), 32'd1);
    sync();
    direct("region", 6'h02, 32'h1000_0000, 32'h0040_0004, 32'h0800_0000, 3'b010);
    sync();
    direct("badop", 6'h04, 32'h0040_0010, 32'h0040_0004, 32'h1010_0004, 3'b100);
    sync();
    // 8-word stream, sink stalls three cycles mid-stream
    fork
      for (int i = 0; i < 8; i++) send(6'h02, 32'h0040_0000 + 32'(i * 4), 32'h0040_0004);
      begin
        repeat (3) @(posedge clk);
        rdy_mode = 0;
        @(negedge clk);
        held = out_instr;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready_low", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_hold", out_instr, held);
        @(posedge clk);
        rdy_mode = 1;
      end
    join
    repeat (4) sync();
    check("stream_drained", 32'(sbq.size()), 32'd0);
    // fill primary and skid, then reset asynchronously mid-cycle
    rdy_mode = 0;
    repeat (2) sync();
    send(6'h02, 32'h0040_0100, 32'h0040_0004);
    send(6'h03, 32'h0040_0104, 32'h0040_0004);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_jump_count", 32'(jump_count), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    check("arst_out_instr", out_instr, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    rdy_mode = 2;
    sync();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        clr_counts = 1'b1;
        sync();
        clr_counts = 1'b0;
      end else rand_word();
    end
    rdy_mode = 1;
    repeat (4) sync();
    check("random_drained", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 65540; i++) send(6'h02, 32'h0040_0010, 32'h0040_0004);
    @(negedge clk);
    check("sat_jump_count", 32'(jump_count), 32'hFFFF);
    sync();
    send(6'h02, 32'h0040_0010, 32'h0040_0004);
    clr_counts = 1'b1;
    sync();
    clr_counts = 1'b0;
    @(negedge clk);
    check("clr_priority", 32'(jump_count), 32'd0);
    repeat (3) sync();
    check("final_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
